// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, transmitter FSM states
// and the parity-bit helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // x is the XOR reduction of the data word
  function automatic logic parity_bit(input logic [1:0] mode, input logic x);
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_req,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_req,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push    = wr_req && !full;
  assign pop     = rd_req && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO. Frame config is captured when a word
// is popped, so config changes only affect frames not yet started.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic [LW-1:0]        fifo_level,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 uart_tx
);
  import uart_pkg::*;

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_nxt, div_cnt, div_cnt_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, head;
  logic                 par_en, par_en_nxt, par_val, par_val_nxt;
  logic                 stop2_q, stop2_nxt, tx_nxt, done_nxt;
  logic                 pop, fifo_full, fifo_empty, bit_end;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (tx_data),
    .wr_req  (tx_valid),
    .full    (fifo_full),
    .rd_data (head),
    .rd_req  (pop),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != ST_IDLE) || !fifo_empty;
  assign bit_end  = (div_cnt == div_q);

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_q;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_en_nxt  = par_en;
    par_val_nxt = par_val;
    stop2_nxt   = stop2_q;
    pop         = 1'b0;
    done_nxt    = 1'b0;
    tx_nxt      = 1'b1;

    if (state != ST_IDLE)
      div_cnt_nxt = bit_end ? '0 : div_cnt + DIV_WIDTH'(1);

    case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop         = 1'b1;
        state_nxt   = ST_START;
        div_nxt     = cfg_div;
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        shreg_nxt   = head;
        par_en_nxt  = (cfg_parity != PAR_NONE);
        par_val_nxt = parity_bit(cfg_parity, ^head);
        stop2_nxt   = cfg_stop2;
      end
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA: if (bit_end) begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt   = par_en ? ST_PARITY : ST_STOP;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + BCW'(1);
          shreg_nxt   = shreg >> 1;
        end
      end
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      // bit_cnt counts stop bits already sent
      ST_STOP: if (bit_end) begin
        if (stop2_q && bit_cnt == '0) begin
          bit_cnt_nxt = BCW'(1);
        end else begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // line is registered from the next state so it never glitches
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
      ST_PARITY: tx_nxt = par_val_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_val <= 1'b0;
      stop2_q <= 1'b0;
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_q   <= div_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_en  <= par_en_nxt;
      par_val <= par_val_nxt;
      stop2_q <= stop2_nxt;
      uart_tx <= tx_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model checked every cycle,
// directed frames with literal waveforms, and a randomized soak.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int REC   = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0, tx_valid7 = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [1:0]  cfg_parity = '0;
  logic        cfg_stop2 = 1'b0;
  logic        tx_ready, tx_busy, tx_done, uart_tx;
  logic [2:0]  fifo_level;
  logic        u7_ready, u7_busy, u7_done, u7_tx;
  logic [1:0]  u7_level;

  int checks = 0, failures = 0, done_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .fifo_level(fifo_level), .tx_busy(tx_busy),
    .tx_done(tx_done), .uart_tx(uart_tx));

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(2), .DIV_WIDTH(16)) u7 (
    .clk(clk), .reset(reset), .tx_data(tx_data[6:0]), .tx_valid(tx_valid7),
    .tx_ready(u7_ready), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .fifo_level(u7_level), .tx_busy(u7_busy),
    .tx_done(u7_done), .uart_tx(u7_tx));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: each queued cycle is {in_frame, done, line} ----
  logic [7:0] m_fifo[$];
  logic [2:0] line_q[$];
  logic [2:0] m_cur = 3'b001;
  int         m_pre;
  logic [7:0] m_w;
  logic       m_push;

  function automatic void build_frame(input logic [7:0] w, input int div,
                                      input logic [1:0] par, input logic st2);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    case (par)
      2'd1: bits.push_back(^w);
      2'd2: bits.push_back(~^w);
      2'd3: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (div + 1) line_q.push_back({2'b10, bits[i]});
    line_q.push_back(3'b011);
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_fifo.delete();
      line_q.delete();
      m_cur = 3'b001;
    end else begin
      m_pre  = m_fifo.size();
      m_push = tx_valid && (m_pre < DEPTH);
      if (line_q.size() == 0 && m_pre > 0) begin
        m_w = m_fifo.pop_front();
        build_frame(m_w, int'(cfg_div), cfg_parity, cfg_stop2);
      end
      if (m_push) m_fifo.push_back(tx_data);
      m_cur = (line_q.size() != 0) ? line_q.pop_front() : 3'b001;
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_done) done_cnt++;
    if (!reset && cmp_en) begin
      chk("uart_tx", uart_tx, m_cur[0]);
      chk("tx_done", tx_done, m_cur[1]);
      chk("tx_busy", tx_busy, m_cur[2] || (m_fifo.size() != 0));
      chk("fifo_level", fifo_level, m_fifo.size());
      chk("tx_ready", tx_ready, m_fifo.size() < DEPTH);
    end
  end

  // ---- directed helpers ----
  logic rec_tx [REC];
  logic rec_done [REC];

  task automatic send_one(input logic [7:0] w, input int div, input logic [1:0] par,
                          input logic st2, input bit use7);
    @(negedge clk);
    cfg_div = 16'(div); cfg_parity = par; cfg_stop2 = st2; tx_data = w;
    if (use7) tx_valid7 = 1'b1; else tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_valid7 = 1'b0;
    rec_tx[0] = 1'b1; rec_done[0] = 1'b0;
    for (int k = 1; k < REC; k++) begin
      @(posedge clk); #1;
      rec_tx[k]   = use7 ? u7_tx : uart_tx;
      rec_done[k] = use7 ? u7_done : tx_done;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((tx_busy || u7_busy) && n < budget) begin @(negedge clk); n++; end
    chk("idle_timeout", {31'd0, tx_busy | u7_busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  logic [9:0] exp10;
  logic [1:0] pm;
  int acc, held, d0, bad;
  logic rdy;

  initial begin
    // reset state, before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_u7_ready", u7_ready, 1);
    chk("rst_u7_level", u7_level, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, div 3, 0x55
    send_one(8'h55, 3, 2'd0, 1'b0, 1'b0);
    exp10 = 10'b1010101010;
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("55_bit%0d_first", b), rec_tx[1 + 4*b], exp10[b]);
      chk($sformatf("55_bit%0d_last", b), rec_tx[4 + 4*b], exp10[b]);
    end
    chk("55_done_edge40", rec_done[40], 0);
    chk("55_done_edge41", rec_done[41], 1);
    chk("55_done_edge42", rec_done[42], 0);
    chk("55_idle_line", rec_tx[41], 1);
    wait_idle(200);

    // parity modes on 0xA5 (four ones): none, even, odd, mark
    for (int p = 0; p < 4; p++) begin
      pm = 2'(p);
      send_one(8'hA5, 0, pm, 1'b0, 1'b0);
      if (p == 0) begin
        chk("a5_none_stop", rec_tx[10], 1);
        chk("a5_none_done", rec_done[11], 1);
      end else begin
        chk($sformatf("a5_par%0d_bit", p), rec_tx[10], (p == 1) ? 0 : 1);
        chk($sformatf("a5_par%0d_done11", p), rec_done[11], 0);
        chk($sformatf("a5_par%0d_done12", p), rec_done[12], 1);
      end
      wait_idle(200);
    end

    // 7 data bits, two stop bits, div 1
    send_one(8'h41, 1, 2'd0, 1'b1, 1'b1);
    exp10 = 10'b1110000010;
    for (int b = 0; b < 10; b++)
      chk($sformatf("u7_bit%0d", b), rec_tx[1 + 2*b], exp10[b]);
    chk("u7_stop2_tail", rec_tx[20], 1);
    chk("u7_done_edge20", rec_done[20], 0);
    chk("u7_done_edge21", rec_done[21], 1);
    wait_idle(200);

    // burst beyond capacity with tx_valid held high
    d0 = done_cnt; acc = 0; held = 0;
    @(negedge clk);
    cfg_div = 16'd0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h10;
    for (int g = 0; g < 2000 && acc < DEPTH + 2; g++) begin
      rdy = tx_ready;
      if (!rdy) held++;
      @(negedge clk);
      if (rdy) begin acc++; tx_data = tx_data + 8'd1; end
    end
    tx_valid = 1'b0;
    chk("burst_held_off", {31'd0, held > 0}, 1);
    chk("burst_accepted", acc, DEPTH + 2);
    wait_idle(1000);
    chk("burst_frames", done_cnt - d0, DEPTH + 2);

    // reset mid data bit with three words queued
    @(negedge clk);
    cfg_div = 16'd3; tx_valid = 1'b1; tx_data = 8'hAA;
    for (int i = 1; i < 4; i++) begin @(negedge clk); tx_data = 8'(i); end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_line", uart_tx, 0);
    chk("pre_reset_level", fifo_level, 3);
    reset = 1'b1;
    #1;
    chk("midrst_uart_tx", uart_tx, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_done", tx_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!uart_tx || tx_busy) bad++;
    end
    chk("no_frame_after_reset", bad, 0);
    send_one(8'h3C, 1, 2'd1, 1'b0, 1'b0);
    wait_idle(200);

    // randomized soak; config churns every cycle to exercise latching
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_valid   = ($urandom_range(0, 3) == 0);
      tx_data    = 8'($urandom);
      cfg_div    = 16'($urandom_range(0, 3));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
    end
    tx_valid = 1'b0;
    wait_idle(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
